// File: rtl/fpu_issue.sv
`timescale 1ns/1ps
// fpu_issue: queues tagged FP requests and runs them one at a time through the FPU core.
// Optional watchdog on a hung core: define FPU_ISSUE_TIMEOUT_EN.

package fpu_p;
    localparam int FPU_32 = 32;
    typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MUL = 2'd2} Operation;
endpackage

module fpu_issue #(
    parameter int WIDTH   = fpu_p::FPU_32,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  fpu_p::Operation  req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fpu_start,
    output fpu_p::Operation  fpu_op,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    input  logic             fpu_busy,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t state, state_next;

    fpu_p::Operation  fifo_op  [DEPTH];
    logic [WIDTH-1:0] fifo_a   [DEPTH];
    logic [WIDTH-1:0] fifo_b   [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop, guard, capture;

    assign req_ready = (count != FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign fpu_start = (state == ISSUE);
    assign wb_valid  = (state == WB);

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TMR_W-1:0] timer;
    logic             expire;

    // Counts WAIT cycles so a core that never drops busy cannot wedge the pipe.
    always_ff @(posedge clk) begin
        if (rst)
            timer <= '0;
        else if (state == ISSUE)
            timer <= '0;
        else if (state == WAIT)
            timer <= timer + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wb_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= req_op;
            fifo_a[wr_ptr]   <= req_a;
            fifo_b[wr_ptr]   <= req_b;
            fifo_tag[wr_ptr] <= req_tag;
        end
    end

    // The first WAIT cycle is a guard: the core's busy has not yet reacted to start.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        expire     = 1'b0;
`endif
        case (state)
            IDLE:  if (count != '0) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (!guard && !fpu_busy) begin
                    capture    = 1'b1;
                    state_next = WB;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (fpu_busy && timer == TMR_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = WB;
                end
`endif
            end
            WB:      if (wb_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            guard   <= 1'b0;
            fpu_op  <= fpu_p::ADD;
            fpu_a   <= '0;
            fpu_b   <= '0;
            wb_tag  <= '0;
            wb_data <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wb_err  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            guard <= (state == ISSUE);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                fpu_op <= fifo_op[rd_ptr];
                fpu_a  <= fifo_a[rd_ptr];
                fpu_b  <= fifo_b[rd_ptr];
                wb_tag <= fifo_tag[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (capture) begin
                wb_data <= fpu_result;
`ifdef FPU_ISSUE_TIMEOUT_EN
                wb_err  <= 1'b0;
`endif
            end
`ifdef FPU_ISSUE_TIMEOUT_EN
            if (expire) begin
                wb_data <= '0;
                wb_err  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
`timescale 1ns/1ps
// Directed testbench for fpu_issue with a behavioural FPU core stub.
// Build with FPU_ISSUE_TIMEOUT_EN defined to exercise the watchdog path.

module tb_fpu_issue;
    import fpu_p::*;

    logic        clk, rst;
    logic        req_valid, req_ready;
    Operation    req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        fpu_start;
    Operation    fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_busy;
    logic [31:0] fpu_result;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_err;

    int checks;
    int errors;
    int cyc;
    int start_cnt;
    int start_cyc[$];
    logic [4:0]  res_tag[$];
    logic [31:0] res_data[$];

    int   s_cyc;
    logic s_active;
    int   busy_lo, busy_hi;
    logic stub_hold;

    fpu_issue #(.WIDTH(32), .TAG_W(5), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_busy(fpu_busy), .fpu_result(fpu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    // Hand-computed IEEE-754 single results for the operand pairs used here.
    function automatic logic [31:0] fpRef(input Operation op, input logic [31:0] a, input logic [31:0] b);
        if (op == ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == SUB && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (op == MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == ADD && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if (op == MUL && a == 32'h40400000 && b == 32'h40400000) return 32'h41100000;
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fpu_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc.push_back(cyc);
        end
        if (!rst && wb_valid && wb_ready) begin
            res_tag.push_back(wb_tag);
            res_data.push_back(wb_data);
        end
    end

    // Core stub: busy is high from busy_lo to busy_hi cycles after the start cycle.
    always @(posedge clk) begin
        if (rst)
            s_active <= 1'b0;
        else if (fpu_start) begin
            s_active   <= 1'b1;
            s_cyc      <= cyc;
            fpu_result <= fpRef(fpu_op, fpu_a, fpu_b);
        end
    end

    always_comb begin
        fpu_busy = stub_hold ||
                   (s_active === 1'b1 && (cyc - s_cyc) >= busy_lo && (cyc - s_cyc) <= busy_hi);
    end

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input Operation op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
        logic took;
        took      = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        for (int i = 0; i < 200 && !took; i++) begin
            took = req_ready;
            tick(1);
        end
        req_valid = 1'b0;
        checkOutput($sformatf("push_accept_tag%0d", tag), took, 1);
    endtask

    task automatic waitWbValid(input int budget, output int edges);
        edges = 0;
        while (wb_valid !== 1'b1 && edges < budget) begin
            tick(1);
            edges++;
        end
        checkOutput("wb_valid_seen", wb_valid, 1);
    endtask

    task automatic waitResults(input int n, input int budget);
        int k;
        k = 0;
        while (res_tag.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput("result_count", res_tag.size(), n);
    endtask

    task automatic clearLogs();
        res_tag.delete();
        res_data.delete();
        start_cyc.delete();
    endtask

    initial begin
        int lat;
        int base;
        logic [4:0]  exp_tag[5];
        logic [31:0] exp_data[5];

        rst = 1'b1; req_valid = 1'b0; req_op = ADD; req_a = '0; req_b = '0; req_tag = '0;
        wb_ready = 1'b0; stub_hold = 1'b0; busy_lo = 2; busy_hi = 3;
        tick(2);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_fpu_start", fpu_start, 0);
        checkOutput("rst_fpu_op", fpu_op, ADD);
        checkOutput("rst_fpu_a", fpu_a, 0);
        checkOutput("rst_fpu_b", fpu_b, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_tag", wb_tag, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_wb_err", wb_err, 0);
        rst = 1'b0;
        tick(1);

        // ADD with busy low in the guard cycle, high for two cycles after it.
        clearLogs();
        base = start_cnt;
        applyStimulus(ADD, 32'h3F800000, 32'h40000000, 5'd3);
        waitWbValid(50, lat);
        checkOutput("add_latency", lat, 6);
        checkOutput("add_tag", wb_tag, 3);
        checkOutput("add_data", wb_data, 32'h40400000);
        checkOutput("add_err", wb_err, 0);
        checkOutput("add_starts", start_cnt - base, 1);
        checkOutput("add_fpu_a_held", fpu_a, 32'h3F800000);
        checkOutput("add_fpu_b_held", fpu_b, 32'h40000000);
        tick(5);
        checkOutput("add_hold_valid", wb_valid, 1);
        checkOutput("add_hold_data", wb_data, 32'h40400000);
        checkOutput("add_hold_starts", start_cnt - base, 1);
        wb_ready = 1'b1;
        tick(1);
        checkOutput("add_released", wb_valid, 0);

        // Minimum latency: core never raises busy.
        clearLogs();
        busy_lo = 1; busy_hi = 0;
        applyStimulus(MUL, 32'h40400000, 32'h40400000, 5'd1);
        waitWbValid(50, lat);
        checkOutput("min_latency", lat, 4);
        checkOutput("min_data", wb_data, 32'h41100000);
        tick(2);

        // SUB then MUL back-to-back with wb_ready held high.
        clearLogs();
        busy_lo = 2; busy_hi = 3;
        base = start_cnt;
        applyStimulus(SUB, 32'h40400000, 32'h3F800000, 5'd7);
        applyStimulus(MUL, 32'h40000000, 32'h40400000, 5'd9);
        waitResults(2, 100);
        checkOutput("b2b_tag0", res_tag[0], 7);
        checkOutput("b2b_data0", res_data[0], 32'h40000000);
        checkOutput("b2b_tag1", res_tag[1], 9);
        checkOutput("b2b_data1", res_data[1], 32'h40C00000);
        tick(10);
        checkOutput("b2b_starts", start_cnt - base, 2);
        checkOutput("b2b_start_gap", start_cyc[1] - start_cyc[0], 7);

        // Back-pressure: five requests fill the pipe, a sixth must be refused.
        clearLogs();
        wb_ready = 1'b0;
        base = start_cnt;
        applyStimulus(ADD, 32'h3F800000, 32'h40000000, 5'd10);
        applyStimulus(SUB, 32'h40400000, 32'h3F800000, 5'd11);
        applyStimulus(MUL, 32'h40000000, 32'h40400000, 5'd12);
        applyStimulus(ADD, 32'h40000000, 32'h40000000, 5'd13);
        applyStimulus(MUL, 32'h40400000, 32'h40400000, 5'd14);
        checkOutput("bp_full_ready", req_ready, 0);
        req_valid = 1'b1; req_op = ADD; req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 5'd15;
        tick(3);
        checkOutput("bp_sixth_ready", req_ready, 0);
        req_valid = 1'b0;
        waitWbValid(50, lat);
        tick(8);
        checkOutput("bp_stall_valid", wb_valid, 1);
        checkOutput("bp_stall_tag", wb_tag, 10);
        checkOutput("bp_stall_data", wb_data, 32'h40400000);
        checkOutput("bp_stall_starts", start_cnt - base, 1);
        wb_ready = 1'b1;
        waitResults(5, 200);
        exp_tag  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        exp_data = '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h40800000, 32'h41100000};
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_tag%0d", i), res_tag[i], exp_tag[i]);
            checkOutput($sformatf("bp_data%0d", i), res_data[i], exp_data[i]);
        end
        tick(30);
        checkOutput("bp_no_sixth", res_tag.size(), 5);
        checkOutput("bp_starts", start_cnt - base, 5);

        // Reset while WAIT with two requests still queued.
        clearLogs();
        busy_lo = 2; busy_hi = 60;
        base = start_cnt;
        applyStimulus(ADD, 32'h3F800000, 32'h40000000, 5'd20);
        applyStimulus(SUB, 32'h40400000, 32'h3F800000, 5'd21);
        applyStimulus(MUL, 32'h40000000, 32'h40400000, 5'd22);
        tick(2);
        checkOutput("mid_starts", start_cnt - base, 1);
        checkOutput("mid_fpu_a", fpu_a, 32'h3F800000);
        rst = 1'b1;
        tick(1);
        checkOutput("mid_rst_wb_valid", wb_valid, 0);
        checkOutput("mid_rst_req_ready", req_ready, 1);
        checkOutput("mid_rst_fpu_a", fpu_a, 0);
        rst = 1'b0;
        base = start_cnt;
        tick(20);
        checkOutput("mid_no_start", start_cnt - base, 0);
        checkOutput("mid_no_result", res_tag.size(), 0);

        // Hung core: busy stuck high.
        clearLogs();
        busy_lo = 2; busy_hi = 3;
        stub_hold = 1'b1;
        wb_ready = 1'b0;
        base = start_cnt;
        applyStimulus(ADD, 32'h3F800000, 32'h40000000, 5'd25);
`ifdef FPU_ISSUE_TIMEOUT_EN
        waitWbValid(200, lat);
        checkOutput("wd_latency", lat, 66);
        checkOutput("wd_after_start", cyc - start_cyc[0], 65);
        checkOutput("wd_err", wb_err, 1);
        checkOutput("wd_data", wb_data, 0);
        checkOutput("wd_tag", wb_tag, 25);
        stub_hold = 1'b0;
        wb_ready = 1'b1;
        tick(2);
`else
        tick(100);
        checkOutput("hang_valid", wb_valid, 0);
        checkOutput("hang_starts", start_cnt - base, 1);
        stub_hold = 1'b0;
        waitWbValid(10, lat);
        checkOutput("hang_release_latency", lat, 1);
        checkOutput("hang_data", wb_data, 32'h40400000);
        checkOutput("hang_tag", wb_tag, 25);
        checkOutput("hang_err", wb_err, 0);
        wb_ready = 1'b1;
        tick(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
